hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_if.sv | 31 +++
 rtl/hazard_controller.sv | 115 +++++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// Bundle of pipeline-stage register tags and hazard-control results exchanged
// between the core pipeline (master) and the hazard controller (slave).
interface hazard_controller_if;
    logic [4:0]  rs_d, rt_d, rs_e, rt_e;
    logic [4:0]  write_reg_e, write_reg_m, write_reg_w;
    logic        reg_write_e, reg_write_m, reg_write_w;
    logic        mem_to_reg_e, mem_to_reg_m;
    logic        branch_d;
    logic        md_start_e, md_op_e, md_use_d;
    logic        stall_f, stall_d, flush_e;
    logic        forward_a_d, forward_b_d;
    logic [1:0]  forward_a_e, forward_b_e;
    logic        md_busy, md_done;
    logic [31:0] stall_cycles;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               branch_d, md_start_e, md_op_e, md_use_d,
        input  stall_f, stall_d, flush_e, forward_a_d, forward_b_d,
               forward_a_e, forward_b_e, md_busy, md_done, stall_cycles
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               branch_d, md_start_e, md_op_e, md_use_d,
        output stall_f, stall_d, flush_e, forward_a_d, forward_b_d,
               forward_a_e, forward_b_e, md_busy, md_done, stall_cycles
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard unit for a 5-stage pipeline: forwarding selects, load-use/branch/mult-div
// stalls, the mult/div occupancy sequencer and a saturating stall-cycle counter.
module hazard_controller #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input logic            clk,
    input logic            rst_n,
    hazard_controller_if.slave hif
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    md_state_t   state;
    logic [5:0]  cnt;
    logic [5:0]  load_val;
    logic        busy_q, done_q;
    logic [31:0] stall_cnt;
    logic        lw_stall, br_stall, md_stall, stall;

    // r0 is hard-wired zero, so a producer targeting it never creates a dependency
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 5'd0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (reg_hit(src, hif.write_reg_m) && hif.reg_write_m)
            return 2'b10;
        else if (reg_hit(src, hif.write_reg_w) && hif.reg_write_w)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        lw_stall = hif.mem_to_reg_e && hif.reg_write_e &&
                   (reg_hit(hif.rs_d, hif.write_reg_e) || reg_hit(hif.rt_d, hif.write_reg_e));
        br_stall = hif.branch_d &&
                   ((hif.reg_write_e &&
                     (reg_hit(hif.rs_d, hif.write_reg_e) || reg_hit(hif.rt_d, hif.write_reg_e))) ||
                    (hif.mem_to_reg_m &&
                     (reg_hit(hif.rs_d, hif.write_reg_m) || reg_hit(hif.rt_d, hif.write_reg_m))));
        md_stall = hif.md_use_d && ((state != IDLE) || hif.md_start_e);
        stall    = lw_stall || br_stall || md_stall;
        load_val = hif.md_op_e ? DIV_LOAD : MUL_LOAD;
    end

    assign hif.stall_f      = stall;
    assign hif.stall_d      = stall;
    assign hif.flush_e      = stall;
    assign hif.forward_a_d  = reg_hit(hif.rs_d, hif.write_reg_m) && hif.reg_write_m;
    assign hif.forward_b_d  = reg_hit(hif.rt_d, hif.write_reg_m) && hif.reg_write_m;
    assign hif.forward_a_e  = fwd_sel(hif.rs_e);
    assign hif.forward_b_e  = fwd_sel(hif.rt_e);
    assign hif.md_busy      = busy_q;
    assign hif.md_done      = done_q;
    assign hif.stall_cycles = stall_cnt;

    // The E cycle plus BUSY plus DONE spans exactly N cycles, so BUSY lasts
    // cnt cycles and hands over to DONE on its final count (cnt==1).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hif.md_start_e) begin
                        cnt    <= load_val;
                        busy_q <= 1'b1;
                        if (load_val == 6'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= BUSY;
                            done_q <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 6'd1;
                    if (cnt <= 6'd1) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= sat_inc(stall_cnt);
    end
endmodule
